// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the hazard FSM state encoding and the counter-width helper.
package pipe_pkg;

    localparam int unsigned DEFAULT_REG_AW = 5;
    localparam logic [31:0] NOP            = 32'h0;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } hz_state_e;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load destination and
// the ID source registers. Register zero never creates a hazard.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = DEFAULT_REG_AW
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              hazard
);

    always_comb begin
        hazard = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, load-use stall and
// branch flush with deferred flush. Define PIPE_HAZARD_PERF_EN for perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW      = DEFAULT_REG_AW,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic              mem_timeout
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    localparam int unsigned CntW = cnt_width(MEM_TIMEOUT);

    hz_state_e       state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic hazard;
    logic mem_stall;
    logic load_use;
    logic stall;
    logic flush;
    logic timeout_hit;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard)
    );

    // Timeout fires when this MEM_WAIT cycle would bring the count to MEM_TIMEOUT.
    always_comb begin
        timeout_hit = (32'(wait_cnt_q) + 32'd1) >= 32'(MEM_TIMEOUT);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StRun: begin
                if (mem_req && !mem_ack) begin
                    state_d    = StMemWait;
                    wait_cnt_d = '0;
                end
            end
            StMemWait: begin
                if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
                if (mem_ack) begin
                    state_d = StRun;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        mem_stall     = (state_q != StRun) || (mem_req && !mem_ack);
        load_use      = hazard && !mem_stall;
        stall         = mem_stall || load_use;
        flush         = !stall && (br_taken || flush_pend_q);
        // A branch seen while stalled is remembered until the pipe moves again.
        flush_pend_d  = stall ? (flush_pend_q || br_taken) : 1'b0;
        mem_timeout_d = mem_timeout_q || (state_d == StErr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            wait_cnt_q    <= '0;
            flush_pend_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            flush_pend_q  <= flush_pend_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Outputs are gated by rst so a live mem_req cannot hold the pipe during reset.
    always_comb begin
        pc_hold     = !rst && stall;
        ifid_hold   = !rst && stall;
        ifid_flush  = !rst && flush;
        idex_bubble = !rst && load_use;
        pipe_freeze = !rst && mem_stall;
        mem_timeout = mem_timeout_q;
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + 32'(pc_hold);
            flush_count_q  <= flush_count_q + 32'(ifid_flush);
        end
    end

    always_comb begin
        stall_cycles = stall_cycles_q;
        flush_count  = flush_count_q;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: a vector table for the
// single-cycle RUN behaviour plus hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       pipe_freeze;
    logic       mem_timeout;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int n_vec;
    int n_fail;

    pipe_hazard_ctrl #(
        .REG_AW      (5),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .br_taken    (br_taken),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .pc_hold     (pc_hold),
        .ifid_hold   (ifid_hold),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .pipe_freeze (pipe_freeze),
        .mem_timeout (mem_timeout)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}
    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b110100;
    localparam logic [5:0] O_FLUSH = 6'b001000;
    localparam logic [5:0] O_MEM   = 6'b110010;
    localparam logic [5:0] O_ERR   = 6'b110011;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       req;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] ert, input logic br, input logic req,
                         input logic ack);
        id_rs       = rs;
        id_rt       = rt;
        ex_mem_read = mr;
        ex_rt       = ert;
        br_taken    = br;
        mem_req     = req;
        mem_ack     = ack;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, mem_timeout};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs %b, required %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: value %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        //          rs     rt     mr    ert    br    req   ack   expected
        vecs[0]  = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE};
        vecs[1]  = '{5'd5,  5'd0,  1'b1, 5'd5,  1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd3,  5'd5,  1'b1, 5'd5,  1'b0, 1'b0, 1'b0, O_LU};
        vecs[3]  = '{5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE};
        vecs[4]  = '{5'd5,  5'd0,  1'b0, 5'd5,  1'b0, 1'b0, 1'b0, O_NONE};
        vecs[5]  = '{5'd6,  5'd8,  1'b1, 5'd7,  1'b0, 1'b0, 1'b0, O_NONE};
        vecs[6]  = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, O_FLUSH};
        // Branch during a load-use stall: no flush now, flush on the next free cycle.
        vecs[7]  = '{5'd2,  5'd9,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0, O_LU};
        vecs[8]  = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_FLUSH};
        vecs[9]  = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE};
        vecs[10] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, O_NONE};
        vecs[11] = '{5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 1'b1, 1'b1, O_LU};
        vecs[12] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b1, O_FLUSH};
        vecs[13] = '{5'd31, 5'd4,  1'b1, 5'd31, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[14] = '{5'd0,  5'd0,  1'b1, 5'd1,  1'b0, 1'b0, 1'b0, O_NONE};

        // Reset with a pending request and a hazard: every output must be low.
        rst = 1'b1;
        drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        #2;
        check("reset_outputs", O_NONE);
        idle();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].ert, vecs[i].br,
                  vecs[i].req, vecs[i].ack);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
            step();
        end

        // Three-cycle memory wait; the ack cycle is still a wait cycle.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1; check("memwait_c0", O_MEM); step();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1; check("memwait_c1", O_MEM); step();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1; check("memwait_ack", O_MEM); step();
        idle();
        #1; check("memwait_release", O_NONE); step();

        // Branch in the second MEM_WAIT cycle flushes right after the ack.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1; check("brwait_req", O_MEM); step();
        #1; check("brwait_mw1", O_MEM); step();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        #1; check("brwait_mw2_br", O_MEM); step();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1; check("brwait_ack", O_MEM); step();
        idle();
        #1; check("brwait_flush", O_FLUSH); step();
        #1; check("brwait_after", O_NONE); step();

        // Ack in the last allowed MEM_WAIT cycle beats the timeout.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1; check("limit_req", O_MEM); step();
        for (int k = 1; k <= 14; k++) begin
            #1; check($sformatf("limit_mw%0d", k), O_MEM); step();
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1; check("limit_ack", O_MEM); step();
        idle();
        #1; check("limit_back_to_run", O_NONE); step();

        // Asynchronous reset in the middle of a wait drops holds without a clock edge.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        #1; check("midwait_before_rst", O_MEM);
        #1; rst = 1'b1;
        #1; check("midwait_rst_async", O_NONE);
        idle();
        step();
        rst = 1'b0;
        #1; check("midwait_released", O_NONE); step();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1; check("midwait_resume_run", O_NONE); step();

        // Fifteen MEM_WAIT cycles without an ack reach ERR; only rst leaves it.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1; check("to_req", O_MEM); step();
        for (int k = 1; k <= 15; k++) begin
            #1; check($sformatf("to_mw%0d", k), O_MEM); step();
        end
        idle();
        #1; check("to_err", O_ERR); step();
        for (int k = 0; k < 3; k++) begin
            drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
            #1; check($sformatf("to_err_hold%0d", k), O_ERR); step();
        end
        #2; rst = 1'b1;
        #1; check("to_rst_clears", O_NONE);
        idle();
        step();
        rst = 1'b0;
        #1; check("to_after_rst", O_NONE); step();

`ifdef PIPE_HAZARD_PERF_EN
        // Fresh counters, three load-use stalls and one flush, then the timeout run.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        #1;
        check32("perf_stall_cycles", stall_cycles, 32'd3);
        check32("perf_flush_count", flush_count, 32'd1);
        step();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step();
        end
        idle();
        #1;
        check("perf_err", O_ERR);
        check32("perf_stall_after_to", stall_cycles, 32'd19);
        check32("perf_flush_after_to", flush_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning maximum memory-wait cycles before the timeout error.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port id_rs / id_rt, input, REG_AW each, meaning the source registers of the instruction in ID.
REQ-006 SHALL have port ex_mem_read, input, 1, meaning the instruction in EX is a load.
REQ-007 SHALL have port ex_rt, input, REG_AW, meaning the destination of the EX load.
REQ-008 SHALL have port br_taken, input, 1, meaning a branch or jump resolved taken in ID this cycle.
REQ-009 SHALL have port mem_req / mem_ack, input, 1 each, meaning the MEM-stage access request and its completion.
REQ-010 SHALL have port pc_hold / ifid_hold / ifid_flush, output, 1 each, meaning PC freeze, IF/ID freeze, and IF/ID instruction zeroing.
REQ-011 SHALL have port idex_bubble, output, 1, meaning ID/EX loads a NOP.
REQ-012 SHALL have port pipe_freeze, output, 1, meaning EX/MEM and MEM/WB hold.
REQ-013 SHALL have port mem_timeout, output, 1, meaning a sticky memory-timeout error.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, ERR, encoded in a 2-bit register.
REQ-015 RUN->MEM_WAIT SHALL occur when mem_req=1 && mem_ack=0; MEM_WAIT->RUN on mem_ack=1; MEM_WAIT->ERR when wait_cnt reaches MEM_TIMEOUT; ERR SHALL be left only by rst.
REQ-016 In MEM_WAIT and ERR: pc_hold=ifid_hold=pipe_freeze=1, idex_bubble=0, ifid_flush=0.
REQ-017 In RUN with mem_req=1 && mem_ack=0, the MEM_WAIT outputs SHALL assert combinationally in the same cycle.
REQ-018 Load-use condition (RUN only): ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
REQ-019 On load-use: pc_hold=1, ifid_hold=1, idex_bubble=1 for that cycle only; no state change.
REQ-020 On br_taken with no stall: ifid_flush=1 in the same cycle.
REQ-021 Priority SHALL be memory wait > load-use > flush; ifid_flush and ifid_hold SHALL never both be 1.
REQ-022 br_taken during a stall cycle SHALL set flush_pend; ifid_flush SHALL assert in the first non-stall cycle, after which flush_pend clears.
REQ-023 wait_cnt SHALL be ceil(log2(MEM_TIMEOUT+1)) bits, cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle, and saturating.
REQ-024 mem_ack in the same cycle that wait_cnt reaches MEM_TIMEOUT SHALL win: MEM_WAIT->RUN.
REQ-025 mem_timeout SHALL be registered, set on entry to ERR, and held until rst.

Reset
REQ-026 rst SHALL force state=RUN, wait_cnt=0, flush_pend=0, mem_timeout=0, and every output to 0 immediately.
REQ-027 rst mid-MEM_WAIT SHALL drop all holds asynchronously; operation resumes in RUN on the first edge after release.

Configuration
REQ-028 With PIPE_HAZARD_PERF_EN defined, the block SHALL add 32-bit outputs stall_cycles and flush_count, which wrap and clear on rst.
REQ-029 stall_cycles SHALL count every cycle with pc_hold=1; flush_count SHALL count every cycle with ifid_flush=1.
REQ-030 Without PIPE_HAZARD_PERF_EN, the block SHALL have neither the ports nor the logic.

Structure
REQ-031 The state enum, the NOP constant 32'h0, and the default REG_AW SHALL live in shared package pipe_pkg.
REQ-032 Hazard comparison SHALL be sub-module load_use_detect (combinational); the FSM, counter and flush_pend stay top-level.

Verification
REQ-033 ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of pc_hold=ifid_hold=idex_bubble=1, then deasserted.
REQ-034 ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
REQ-035 mem_req=1, mem_ack low for 3 cycles -> pipe_freeze=1 for exactly 3 cycles, RUN on the ack edge.
REQ-036 br_taken during the 2nd MEM_WAIT cycle -> ifid_flush=1 exactly in the first cycle after mem_ack.
REQ-037 mem_ack withheld for 15 cycles -> ERR, mem_timeout=1 and held; rst clears all.
REQ-038 PIPE_HAZARD_PERF_EN build, previous scenario preceded by 3 stall cycles and 1 flush -> stall_cycles=3, flush_count=1.
